// File: rtl/xor_pkg.sv
// Shared definitions for the XOR checksum datapath: FSM state encoding
// and the default word width.
package xor_pkg;

    localparam int XOR_DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/xor_checksum_if.sv
// Stream-in / result-out handshake bundle for xor_checksum.
// The master is the producer/consumer side. The slave is the checksum block.
interface xor_checksum_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [WIDTH-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_sum, out_count, out_overflow, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_sum, out_count, out_overflow, out_valid
    );
endinterface

// File: rtl/xor_checksum_xor.sv
// Parameterized bitwise XOR gate used to fold words into the accumulator.
module Xor #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = a ^ b;
endmodule

// File: rtl/xor_checksum.sv
// Streaming XOR-checksum accumulator. It folds each framed word into a running
// checksum and counts the words, saturating the count. It then holds the
// result on the output handshake until the consumer takes it.
module xor_checksum
    import xor_pkg::*;
#(
    parameter int WIDTH = XOR_DEFAULT_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    xor_checksum_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] xor_y;
    logic             in_ready_c;
    logic             out_valid_c;

    Xor #(.WIDTH(WIDTH)) u_xor (
        .a (acc_q),
        .b (bus.in_data),
        .y (xor_y)
    );

    // Next-state, accumulator/counter update and handshake decode from registered state
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                acc_d      = '0;
                count_d    = '0;
                ovf_d      = 1'b0;
                if (bus.in_valid) begin
                    acc_d   = bus.in_data;
                    count_d = CNT_W'(1);
                    state_d = bus.in_last ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    acc_d = xor_y;
                    if (count_q == '1) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (bus.in_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                count_d = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = out_valid_c;
    assign bus.out_sum      = out_valid_c ? acc_q : '0;
    assign bus.out_count    = out_valid_c ? count_q : '0;
    assign bus.out_overflow = out_valid_c & ovf_q;

endmodule

// File: tb/tb_xor_checksum.sv
// Directed testbench for xor_checksum. It uses a default-width instance and
// a narrow-counter instance for saturation.
module tb_xor_checksum;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    xor_checksum_if #(.WIDTH(16), .CNT_W(8)) bus ();
    xor_checksum_if #(.WIDTH(16), .CNT_W(2)) bus2 ();

    xor_checksum #(.WIDTH(16), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    xor_checksum #(.WIDTH(16), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: present one word across the next rising edge
    task automatic send(input logic [15:0] d, input logic last);
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send2(input logic [15:0] d, input logic last);
        bus2.in_data  = d;
        bus2.in_last  = last;
        bus2.in_valid = 1'b1;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        bus2.in_last  = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [15:0] s, input logic [7:0] c,
                           input logic o);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_sum"},   32'(bus.out_sum), 32'(s));
        chk({tag, "_count"}, 32'(bus.out_count), 32'(c));
        chk({tag, "_ovf"},   32'(bus.out_overflow), 32'(o));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_sum"},   32'(bus.out_sum), 32'd0);
        chk({tag, "_count"}, 32'(bus.out_count), 32'd0);
        chk({tag, "_ovf"},   32'(bus.out_overflow), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        bus2.in_data   = '0;
        bus2.in_valid  = 1'b0;
        bus2.in_last   = 1'b0;
        bus2.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk_idle("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Single-word frame
        send(16'h1234, 1'b1);
        chk_res("single", 16'h1234, 8'd1, 1'b0);
        @(negedge clk);
        chk_idle("single_after");

        // Multi-word frames
        send(16'h0000, 1'b0);
        send(16'hFFFF, 1'b1);
        chk_res("multi2", 16'hFFFF, 8'd2, 1'b0);
        @(negedge clk);
        send(16'hAAAA, 1'b0);
        send(16'h5555, 1'b0);
        chk("multi3_mid_valid", 32'(bus.out_valid), 32'd0);
        chk("multi3_mid_sum", 32'(bus.out_sum), 32'd0);
        send(16'hFFFF, 1'b1);
        chk_res("multi3", 16'h0000, 8'd3, 1'b0);
        @(negedge clk);

        // Gaps in in_valid
        send(16'h3CC3, 1'b0);
        repeat (3) begin
            chk("gap_ready", 32'(bus.in_ready), 32'd1);
            chk("gap_valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        send(16'h0FF0, 1'b1);
        chk_res("gap", 16'h3333, 8'd2, 1'b0);
        @(negedge clk);

        // Output backpressure with an offered input word
        bus.out_ready = 1'b0;
        send(16'h0101, 1'b0);
        send(16'h1010, 1'b1);
        chk_res("bp_first", 16'h1111, 8'd2, 1'b0);
        bus.in_data  = 16'hBEEF;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_res("bp_hold", 16'h1111, 8'd2, 1'b0);
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk_idle("bp_release");
        send(16'h0F0F, 1'b1);
        chk_res("bp_next", 16'h0F0F, 8'd1, 1'b0);
        @(negedge clk);

        // Count saturation with CNT_W=2
        for (int i = 0; i < 4; i++) send2(16'h0001, 1'b0);
        chk("ovf_mid_valid", 32'(bus2.out_valid), 32'd0);
        chk("ovf_mid_count", 32'(bus2.out_count), 32'd0);
        send2(16'h0001, 1'b1);
        chk("ovf_valid", 32'(bus2.out_valid), 32'd1);
        chk("ovf_count", 32'(bus2.out_count), 32'd3);
        chk("ovf_flag",  32'(bus2.out_overflow), 32'd1);
        chk("ovf_sum",   32'(bus2.out_sum), 32'h0001);
        @(negedge clk);
        chk("ovf_clear", 32'(bus2.out_overflow), 32'd0);

        // Asynchronous reset mid-frame
        send(16'hFFFF, 1'b0);
        send(16'h00FF, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(16'h1234, 1'b1);
        chk_res("post_rst", 16'h1234, 8'd1, 1'b0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_checksum.md
# xor_checksum

Streaming XOR-checksum accumulator placed downstream of the parameterized `Xor` gate. It accepts a framed stream of WIDTH-bit words over a valid/ready handshake and folds each word into a running accumulator through one `Xor #(WIDTH)` instance. On the frame's last word it presents the checksum and the word count on a held output handshake. It produces parity/checksum words for the hw7 datapath exercises.

## Interface
- `WIDTH`, 16, data and checksum width in bits
- `CNT_W`, 8, word-counter width; maximum countable frame length is 2^CNT_W−1
- `clk` input 1: single clock; all state updates on the rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `in_data` input WIDTH: input word
- `in_valid` input 1: `in_data`/`in_last` are valid
- `in_last` input 1: current word ends the frame
- `in_ready` output 1: block accepts a word this cycle
- `out_sum` output WIDTH: XOR of all words in the frame
- `out_count` output CNT_W: number of words in the frame, saturating
- `out_overflow` output 1: the frame exceeded 2^CNT_W−1 words
- `out_valid` output 1: result is available
- `out_ready` input 1: consumer takes the result

## Operation
- **Accept.** A word is accepted when `in_valid && in_ready` at a rising edge.
- **IDLE state.**
  - `in_ready`=1; accumulator=0, count=0, overflow=0.
  - Accept: acc←`in_data`, count←1.
  - Next state is DONE if `in_last`, else ACCUM.
- **ACCUM state.**
  - `in_ready`=1.
  - Accept: acc←acc ^ `in_data` (through the `Xor` instance), count←count+1.
  - The count saturates at 2^CNT_W−1. An increment attempted at saturation sets sticky overflow.
  - Accept with `in_last` moves to DONE.
  - With no accept, all state holds; gaps in `in_valid` are legal.
- **DONE state.**
  - `in_ready`=0, `out_valid`=1.
  - `out_sum`, `out_count` and `out_overflow` stay stable until `out_ready`=1.
  - On `out_ready`, move to IDLE and clear acc, count and overflow.
- **Output outside DONE.** `out_sum`, `out_count` and `out_overflow` read 0; only the accumulator's value is exposed in DONE.
- **Illegal state encodings** recover to IDLE.
- **Reset** (`rst_n` low, at any time including mid-frame):
  - Immediately go to IDLE and drop any partial frame.
  - All outputs read 0 except `in_ready`, which is 1.
  - After release, the next accepted word starts a new frame.

## Timing
- `in_ready` and `out_valid` are decoded from the registered state only. There is no combinational path from `in_valid`/`out_ready` to `in_ready`/`out_valid`.
- Latency: `out_valid` rises in the cycle after the edge that accepts the last word.
- Throughput: one word per cycle inside a frame.
- Between frames there is at least one DONE cycle plus one IDLE transition. The minimum frame period is N+1 cycles with `out_ready` held at 1.
- Simultaneous events: in DONE, `in_ready`=0, so no input is accepted in the same cycle that the result is consumed. The first word of the next frame is accepted no earlier than the cycle after the `out_ready` handshake.
- The upstream source must hold `in_data`/`in_last` stable while `in_valid`=1 and `in_ready`=0.

## Structure
- Shared package `xor_pkg` holds:
  - state encoding constants `ST_IDLE`=2'd0, `ST_ACCUM`=2'd1, `ST_DONE`=2'd2;
  - the default width constant 16.
- One sub-module: an instance of the existing `Xor #(WIDTH)` gate, computing acc ^ `in_data`.
- The FSM, counter, saturation logic and registers live in `xor_checksum`.

## Test plan
- **Single-word frame.** `in_data`=0x1234 with `in_last`=1, `out_ready`=1. Next cycle: `out_valid`=1, `out_sum`=0x1234, `out_count`=1, `out_overflow`=0. The following cycle: `in_ready`=1.
- **Multi-word frames.**
  - Frame 0x0000, 0xFFFF(last) gives `out_sum`=0xFFFF, `out_count`=2.
  - Then frame 0xAAAA, 0x5555, 0xFFFF(last) gives `out_sum`=0x0000, `out_count`=3.
- **Input gaps.** 0x3CC3, then `in_valid`=0 for 3 cycles, then 0x0FF0(last) gives `out_sum`=0x3333, `out_count`=2.
- **Output backpressure.**
  - Hold `out_ready`=0 for 5 cycles after the result appears. During that time `out_valid`=1, `in_ready`=0, outputs unchanged, and any offered `in_valid` word is not accepted.
  - Raise `out_ready`. Next cycle: IDLE, `in_ready`=1, outputs 0.
- **Overflow** (CNT_W=2). Five words of 0x0001, last on the fifth, give `out_count`=3, `out_overflow`=1, `out_sum`=0x0001.
- **Reset mid-frame.**
  - Accept 0xFFFF and 0x00FF, then assert `rst_n`=0 asynchronously. Immediately: `out_valid`=0, outputs 0, `in_ready`=1.
  - After release, frame 0x1234(last) gives `out_sum`=0x1234, `out_count`=1.
